// File: rtl/psc_trigger_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : psc_trigger_pkg
//  Description : Shared state encodings, K-codes and payload constants for the
//                PSC frame scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package psc_trigger_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_TRIG_SOF = 3'd1;
  localparam state_t ST_TRIG_PAY = 3'd2;
  localparam state_t ST_STAT_SOF = 3'd3;
  localparam state_t ST_STAT_PAY = 3'd4;
  localparam state_t ST_CRC      = 3'd5;

  localparam logic [7:0] K_IDLE     = 8'hBC;
  localparam logic [7:0] K_SOF_TRIG = 8'h3C;
  localparam logic [7:0] K_SOF_STAT = 8'h7C;

  localparam logic [7:0] PAY_TRIG = 8'hA5;
  localparam logic [7:0] PAY_HB   = 8'hFF;
  localparam logic [7:0] PAY_CRC  = 8'h00;

  // Wide enough for the largest supported payload length (15).
  typedef logic [3:0] frame_len_t;

endpackage
`default_nettype wire

// File: rtl/psc_heartbeat_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : psc_heartbeat_timer
//  Description : Reloadable down-counter; expired is high once HB_PERIOD-1
//                counted ticks have elapsed since the last reload.
//  Revision    : 1.0 - initial release
// ============================================================================
module psc_heartbeat_timer #(
  parameter int HB_PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic reload,
  output logic expired
);

  localparam int CW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(HB_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = RELOAD_VAL;
    end else if (tick_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= RELOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/psc_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : psc_frame_scheduler
//  Description : Byte-slot scheduler for trigger, status and heartbeat frames
//                feeding the PSC frame encoder. Optional macro TRIG_SEQ_EN
//                replaces the constant trigger payload with a sequence number.
//  Revision    : 1.0 - initial release
// ============================================================================
module psc_frame_scheduler
  import psc_trigger_pkg::*;
#(
  parameter int         STATUS_LEN = 4,
  parameter int         HB_PERIOD  = 1000,
  parameter logic [7:0] IDLE_BYTE  = K_IDLE,
  parameter logic [7:0] SOF_TRIG   = K_SOF_TRIG,
  parameter logic [7:0] SOF_STAT   = K_SOF_STAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_tick,
  input  logic       enable,
  input  logic       trigger_pulse,
  input  logic       status_valid,
  input  logic [7:0] status_data,
  output logic       status_ready,
  output logic [7:0] tx_byte,
  output logic       is_control_byte,
  output logic       is_crc_byte,
  output logic       crc_reset,
  output logic       busy,
  output logic [7:0] trig_drop_cnt,
  output logic       stat_underrun
);

  localparam frame_len_t LAST_PAY = frame_len_t'(STATUS_LEN);

  state_t     state_q,     state_d;
  logic       hb_frame_q,  hb_frame_d;
  frame_len_t pay_cnt_q,   pay_cnt_d;
  logic       trig_pend_q, trig_pend_d;
  logic [7:0] drop_cnt_q,  drop_cnt_d;
  logic       underrun_q,  underrun_d;
  logic [7:0] tx_byte_q,   tx_byte_d;
  logic       ctrl_q,      ctrl_d;
  logic       crc_byte_q,  crc_byte_d;
  logic       crc_reset_q, crc_reset_d;
`ifdef TRIG_SEQ_EN
  logic [7:0] seq_q,       seq_d;
`endif

  logic trig_take;
  logic hb_expired;
  logic hb_tick;
  logic hb_reload;

  assign hb_tick   = byte_tick && (state_q == ST_IDLE);
  assign hb_reload = hb_tick && (state_d != ST_IDLE);

  psc_heartbeat_timer #(
    .HB_PERIOD (HB_PERIOD)
  ) u_hb_timer (
    .clk     (clk),
    .reset   (reset),
    .tick_en (hb_tick),
    .reload  (hb_reload),
    .expired (hb_expired)
  );

  always_comb begin
    state_d      = state_q;
    hb_frame_d   = hb_frame_q;
    pay_cnt_d    = pay_cnt_q;
    trig_pend_d  = trig_pend_q;
    drop_cnt_d   = drop_cnt_q;
    underrun_d   = underrun_q;
    tx_byte_d    = tx_byte_q;
    ctrl_d       = ctrl_q;
    crc_byte_d   = crc_byte_q;
    crc_reset_d  = crc_reset_q;
    status_ready = 1'b0;
    trig_take    = 1'b0;
`ifdef TRIG_SEQ_EN
    seq_d        = seq_q;
`endif

    if (byte_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (enable && trig_pend_q) begin
            state_d   = ST_TRIG_SOF;
            trig_take = 1'b1;
          end else if (enable && status_valid) begin
            state_d    = ST_STAT_SOF;
            hb_frame_d = 1'b0;
          end else if (enable && hb_expired) begin
            state_d    = ST_STAT_SOF;
            hb_frame_d = 1'b1;
          end
        end
        ST_TRIG_SOF: state_d = ST_TRIG_PAY;
        ST_TRIG_PAY: state_d = ST_CRC;
        ST_STAT_SOF: begin
          state_d   = ST_STAT_PAY;
          pay_cnt_d = frame_len_t'(1);
        end
        ST_STAT_PAY: begin
          if (pay_cnt_q == LAST_PAY) begin
            state_d = ST_CRC;
          end else begin
            pay_cnt_d = pay_cnt_q + frame_len_t'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Output registers describe the slot being entered on this tick.
      ctrl_d      = 1'b0;
      crc_byte_d  = 1'b0;
      crc_reset_d = 1'b0;
      case (state_d)
        ST_TRIG_SOF: begin
          tx_byte_d   = SOF_TRIG;
          ctrl_d      = 1'b1;
          crc_reset_d = 1'b1;
        end
        ST_TRIG_PAY: begin
`ifdef TRIG_SEQ_EN
          tx_byte_d = seq_q;
          seq_d     = seq_q + 8'd1;
`else
          tx_byte_d = PAY_TRIG;
`endif
        end
        ST_STAT_SOF: begin
          tx_byte_d   = SOF_STAT;
          ctrl_d      = 1'b1;
          crc_reset_d = 1'b1;
        end
        ST_STAT_PAY: begin
          if (hb_frame_d) begin
            tx_byte_d = PAY_HB;
          end else begin
            status_ready = 1'b1;
            if (status_valid) begin
              tx_byte_d = status_data;
            end else begin
              tx_byte_d  = 8'h00;
              underrun_d = 1'b1;
            end
          end
        end
        ST_CRC: begin
          tx_byte_d  = PAY_CRC;
          crc_byte_d = 1'b1;
        end
        default: begin
          tx_byte_d = IDLE_BYTE;
          ctrl_d    = 1'b1;
        end
      endcase
    end

    // A pulse on the same clock that consumes the pending request re-arms it without a drop.
    if (!enable) begin
      trig_pend_d = 1'b0;
    end else if (trigger_pulse) begin
      trig_pend_d = 1'b1;
      if (trig_pend_q && !trig_take && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (trig_take) begin
      trig_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hb_frame_q  <= 1'b0;
      pay_cnt_q   <= '0;
      trig_pend_q <= 1'b0;
      drop_cnt_q  <= 8'h00;
      underrun_q  <= 1'b0;
      tx_byte_q   <= IDLE_BYTE;
      ctrl_q      <= 1'b1;
      crc_byte_q  <= 1'b0;
      crc_reset_q <= 1'b0;
`ifdef TRIG_SEQ_EN
      seq_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      hb_frame_q  <= hb_frame_d;
      pay_cnt_q   <= pay_cnt_d;
      trig_pend_q <= trig_pend_d;
      drop_cnt_q  <= drop_cnt_d;
      underrun_q  <= underrun_d;
      tx_byte_q   <= tx_byte_d;
      ctrl_q      <= ctrl_d;
      crc_byte_q  <= crc_byte_d;
      crc_reset_q <= crc_reset_d;
`ifdef TRIG_SEQ_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign tx_byte         = tx_byte_q;
  assign is_control_byte = ctrl_q;
  assign is_crc_byte     = crc_byte_q;
  assign crc_reset       = crc_reset_q;
  assign busy            = (state_q != ST_IDLE);
  assign trig_drop_cnt   = drop_cnt_q;
  assign stat_underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_psc_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_psc_frame_scheduler
//  Description : Directed self-checking bench for psc_frame_scheduler
//                (STATUS_LEN=4, HB_PERIOD=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psc_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_tick;
  logic       enable;
  logic       trigger_pulse;
  logic       status_valid;
  logic [7:0] status_data;
  logic       status_ready;
  logic [7:0] tx_byte;
  logic       is_control_byte;
  logic       is_crc_byte;
  logic       crc_reset;
  logic       busy;
  logic [7:0] trig_drop_cnt;
  logic       stat_underrun;

  int checks   = 0;
  int failures = 0;
  int rdy_cnt  = 0;
`ifdef TRIG_SEQ_EN
  logic [7:0] exp_seq = 8'h00;
`endif

  psc_frame_scheduler #(
    .STATUS_LEN (4),
    .HB_PERIOD  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .byte_tick       (byte_tick),
    .enable          (enable),
    .trigger_pulse   (trigger_pulse),
    .status_valid    (status_valid),
    .status_data     (status_data),
    .status_ready    (status_ready),
    .tx_byte         (tx_byte),
    .is_control_byte (is_control_byte),
    .is_crc_byte     (is_crc_byte),
    .crc_reset       (crc_reset),
    .busy            (busy),
    .trig_drop_cnt   (trig_drop_cnt),
    .stat_underrun   (stat_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every task starts and ends 1ns after a rising edge.
  task automatic idle_clk();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    byte_tick = 1'b1;
    #1;
    if (status_ready) rdy_cnt++;
    @(posedge clk); #1;
    byte_tick = 1'b0;
  endtask

  task automatic pulse();
    trigger_pulse = 1'b1;
    idle_clk();
    trigger_pulse = 1'b0;
  endtask

  task automatic slot(input string tag, input logic [7:0] tx, input logic ctrl,
                      input logic crc, input logic crst);
    tick();
    chk(tag, {20'h0, tx_byte, is_control_byte, is_crc_byte, crc_reset, busy},
        {20'h0, tx, ctrl, crc, crst, (tx != 8'hBC)});
  endtask

  task automatic trig_pay_slot(input string tag);
`ifdef TRIG_SEQ_EN
    slot(tag, exp_seq, 1'b0, 1'b0, 1'b0);
    exp_seq = exp_seq + 8'd1;
`else
    slot(tag, 8'hA5, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    reset         = 1'b0;
    byte_tick     = 1'b0;
    enable        = 1'b1;
    trigger_pulse = 1'b0;
    status_valid  = 1'b0;
    status_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_clk();
    chk("reset_out", {20'h0, tx_byte, is_control_byte, is_crc_byte, crc_reset, busy},
        {20'h0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_misc", {trig_drop_cnt, stat_underrun, status_ready}, {8'h00, 1'b0, 1'b0});

    // Single trigger, then a re-trigger during the payload slot (no drop).
    pulse();
    slot("trig_sof", 8'h3C, 1'b1, 1'b0, 1'b1);
    trig_pay_slot("trig_pay");
    slot("trig_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("trig_idle", 8'hBC, 1'b1, 1'b0, 1'b0);
    pulse();
    slot("trig2_sof", 8'h3C, 1'b1, 1'b0, 1'b1);
    trig_pay_slot("trig2_pay");
    pulse();
    chk("retrig_nodrop", trig_drop_cnt, 8'h00);
    slot("trig2_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("trig2_idle", 8'hBC, 1'b1, 1'b0, 1'b0);
    slot("trig3_sof", 8'h3C, 1'b1, 1'b0, 1'b1);
    trig_pay_slot("trig3_pay");
    slot("trig3_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("trig3_idle", 8'hBC, 1'b1, 1'b0, 1'b0);

    // Status frame 11,22,33,44.
    rdy_cnt = 0;
    status_valid = 1'b1;
    slot("stat_sof", 8'h7C, 1'b1, 1'b0, 1'b1);
    status_data = 8'h11; slot("stat_p0", 8'h11, 1'b0, 1'b0, 1'b0);
    status_data = 8'h22; slot("stat_p1", 8'h22, 1'b0, 1'b0, 1'b0);
    status_data = 8'h33; slot("stat_p2", 8'h33, 1'b0, 1'b0, 1'b0);
    status_data = 8'h44; slot("stat_p3", 8'h44, 1'b0, 1'b0, 1'b0);
    status_valid = 1'b0;
    slot("stat_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("stat_idle", 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("stat_ready_cnt", rdy_cnt, 4);
    chk("stat_no_underrun", stat_underrun, 1'b0);

    // Trigger and status pending together: trigger first.
    status_valid = 1'b1;
    status_data  = 8'h55;
    pulse();
    slot("both_trig_sof", 8'h3C, 1'b1, 1'b0, 1'b1);
    trig_pay_slot("both_trig_pay");
    slot("both_trig_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("both_idle", 8'hBC, 1'b1, 1'b0, 1'b0);
    slot("both_stat_sof", 8'h7C, 1'b1, 1'b0, 1'b1);
    slot("both_stat_p0", 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    status_valid = 1'b0;
    slot("both_stat_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("both_idle2", 8'hBC, 1'b1, 1'b0, 1'b0);

    // Overruns inside a status frame.
    status_valid = 1'b1;
    status_data  = 8'h66;
    slot("ovr_stat_sof", 8'h7C, 1'b1, 1'b0, 1'b1);
    pulse(); pulse(); pulse();
    chk("ovr_drop2", trig_drop_cnt, 8'h02);
    repeat (4) tick();
    status_valid = 1'b0;
    slot("ovr_stat_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("ovr_idle", 8'hBC, 1'b1, 1'b0, 1'b0);
    slot("ovr_trig_sof", 8'h3C, 1'b1, 1'b0, 1'b1);
    trig_pay_slot("ovr_trig_pay");
    slot("ovr_trig_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("ovr_idle2", 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("ovr_drop_hold", trig_drop_cnt, 8'h02);
    pulse();
    trigger_pulse = 1'b1;
    repeat (300) idle_clk();
    trigger_pulse = 1'b0;
    chk("ovr_drop_sat", trig_drop_cnt, 8'hFF);

    // Drop the pending trigger, then underrun and reset mid-frame.
    enable = 1'b0;
    idle_clk();
    enable = 1'b1;
    rdy_cnt = 0;
    status_valid = 1'b1;
    slot("und_sof", 8'h7C, 1'b1, 1'b0, 1'b1);
    status_valid = 1'b0;
    slot("und_p0", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("und_flag", {stat_underrun, rdy_cnt[7:0]}, {1'b1, 8'd1});
    status_valid = 1'b1;
    status_data  = 8'h77;
    slot("und_p1", 8'h77, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle_clk();
    chk("midrst_out", {20'h0, tx_byte, is_control_byte, is_crc_byte, crc_reset, busy},
        {20'h0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("midrst_misc", {trig_drop_cnt, stat_underrun}, {8'h00, 1'b0});
    status_valid = 1'b0;
    reset = 1'b1;
    idle_clk();

    // Heartbeat after 8 idle ticks, then disable mid-frame.
    rdy_cnt = 0;
    repeat (6) tick();
    slot("hb_idle7", 8'hBC, 1'b1, 1'b0, 1'b0);
    slot("hb_sof", 8'h7C, 1'b1, 1'b0, 1'b1);
    slot("hb_p0", 8'hFF, 1'b0, 1'b0, 1'b0);
    slot("hb_p1", 8'hFF, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    slot("hb_p2", 8'hFF, 1'b0, 1'b0, 1'b0);
    slot("hb_p3", 8'hFF, 1'b0, 1'b0, 1'b0);
    slot("hb_crc", 8'h00, 1'b0, 1'b1, 1'b0);
    slot("hb_idle", 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("hb_no_ready", rdy_cnt, 0);
    pulse();
    status_valid = 1'b1;
    slot("dis_idle0", 8'hBC, 1'b1, 1'b0, 1'b0);
    status_valid = 1'b0;
    enable = 1'b1;
    slot("dis_trig_ignored", 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("dis_drop", {trig_drop_cnt, stat_underrun}, {8'h00, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
